// File: rtl/twos_comp_defs.sv
// Shared definitions for the bit-serial two's-complement negator.
// State encodings and the default operand width.
package twos_comp_defs;

  localparam int TC_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COPY   = 2'd1,
    ST_INVERT = 2'd2,
    ST_DONE   = 2'd3
  } tc_state_t;

endpackage

// File: rtl/twos_comp_bit_cell.sv
// Mealy cell of the copy-until-first-1-then-invert rule.
// Result bit is b flipped once a 1 has been seen on an earlier bit.
module twos_comp_bit_cell (
  input  logic b,
  input  logic seen_one,
  output logic r,
  output logic next_seen
);

  // Pure combinational cell, no state of its own
  always_comb begin
    r         = b ^ seen_one;
    next_seen = seen_one | b;
  end

endmodule

// File: rtl/serial_twos_comp.sv
// Bit-serial WIDTH-bit negator, LSB-first, valid/ready on both sides.
// Optional bitstream ports under SERIAL_TWOS_COMP_BITSTREAM_EN.
module serial_twos_comp
  import twos_comp_defs::*;
#(
  parameter int WIDTH = TC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ovf
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
  ,
  output logic             ser_bit,
  output logic             ser_vld
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  tc_state_t        r_state;
  // Operand bits shift out at the LSB while result bits
  // enter at the MSB, so one register serves both roles.
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_zero;
  logic             r_ovf;

  logic             w_b;
  logic             w_r;
  logic             w_next_seen;

  assign w_b = r_sh[0];

  twos_comp_bit_cell u_cell (
    .b         (w_b),
    .seen_one  (r_seen),
    .r         (w_r),
    .next_seen (w_next_seen)
  );

  // FSM, shift/count datapath and registered handshake/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_seen      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sh       <= in_data;
            r_cnt      <= '0;
            r_seen     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_COPY;
          end
        end
        ST_COPY, ST_INVERT: begin
          r_sh   <= {w_r, r_sh[WIDTH-1:1]};
          r_seen <= w_next_seen;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= {w_r, r_sh[WIDTH-1:1]};
            r_zero      <= ~w_next_seen;
            // first 1 arriving on the MSB means a == most negative
            r_ovf       <= w_b & ~r_seen;
          end else begin
            r_state <= w_next_seen ? ST_INVERT : ST_COPY;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_zero;
  assign out_ovf   = r_ovf;

`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
  // Live result bit for a downstream bit-serial consumer
  always_comb begin
    ser_vld = ~rst & ((r_state == ST_COPY) | (r_state == ST_INVERT));
    ser_bit = ser_vld & w_r;
  end
`endif

endmodule

// File: tb/tb_serial_twos_comp.sv
// Directed bench for serial_twos_comp at WIDTH=3 and WIDTH=8.
// Bitstream checks compile in with SERIAL_TWOS_COMP_BITSTREAM_EN.
module tb_serial_twos_comp;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       iv3, ir3, ov3, or3, oz3, oo3;
  logic [2:0] id3, od3;

  logic       iv8, ir8, ov8, or8, oz8, oo8;
  logic [7:0] id8, od8;
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
  logic       sb3, sv3, sb8, sv8;
`endif

  serial_twos_comp #(.WIDTH(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv3),
    .in_ready  (ir3),
    .in_data   (id3),
    .out_valid (ov3),
    .out_ready (or3),
    .out_data  (od3),
    .out_zero  (oz3),
    .out_ovf   (oo3)
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
    ,
    .ser_bit   (sb3),
    .ser_vld   (sv3)
`endif
  );

  serial_twos_comp #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .in_data   (id8),
    .out_valid (ov8),
    .out_ready (or8),
    .out_data  (od8),
    .out_zero  (oz8),
    .out_ovf   (oo8)
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
    ,
    .ser_bit   (sb8),
    .ser_vld   (sv8)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] f;
    logic       z;
    logic       o;
  } vec_t;

  vec_t tv [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One WIDTH=3 word with out_ready high; checks latency too
  task automatic run3(input logic [2:0] a,
                      input logic [2:0] f,
                      input logic z,
                      input logic o);
    int k;
    logic busy_bad;
    or3 = 1'b1;
    iv3 = 1'b1;
    id3 = a;
    chk("ready_before_accept", 32'(ir3), 32'd1);
    tick;
    iv3 = 1'b0;
    id3 = 3'd0;
    k = 0;
    busy_bad = 1'b0;
    while (!ov3 && k < 20) begin
      if (ir3) busy_bad = 1'b1;
      tick;
      k++;
    end
    if (ir3) busy_bad = 1'b1;
    chk("latency3", 32'(k), 32'd3);
    chk("in_ready_busy", 32'(busy_bad), 32'd0);
    chk("out_data3", 32'(od3), 32'(f));
    chk("out_zero3", 32'(oz3), 32'(z));
    chk("out_ovf3", 32'(oo3), 32'(o));
    tick;
    chk("valid_one_cycle", 32'(ov3), 32'd0);
    chk("ready_after_done", 32'(ir3), 32'd1);
  endtask

  initial begin
    logic       bad;
    int         k;
    logic [7:0] exp8;

    tv[0] = '{3'd0, 3'd0, 1'b1, 1'b0};
    tv[1] = '{3'd1, 3'd7, 1'b0, 1'b0};
    tv[2] = '{3'd2, 3'd6, 1'b0, 1'b0};
    tv[3] = '{3'd3, 3'd5, 1'b0, 1'b0};
    tv[4] = '{3'd4, 3'd4, 1'b0, 1'b1};
    tv[5] = '{3'd5, 3'd3, 1'b0, 1'b0};
    tv[6] = '{3'd6, 3'd2, 1'b0, 1'b0};
    tv[7] = '{3'd7, 3'd1, 1'b0, 1'b0};

    iv3 = 1'b0; id3 = '0; or3 = 1'b1;
    iv8 = 1'b0; id8 = '0; or8 = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;

    chk("rst_in_ready", 32'(ir3), 32'd1);
    chk("rst_out_valid", 32'(ov3), 32'd0);
    chk("rst_out_data", 32'(od3), 32'd0);
    chk("rst_out_zero", 32'(oz3), 32'd0);
    chk("rst_out_ovf", 32'(oo3), 32'd0);
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
    chk("rst_ser_vld", 32'(sv3), 32'd0);
`endif

    // directed first word
    run3(3'b011, 3'b101, 1'b0, 1'b0);

    // full sweep, back-to-back
    for (int i = 0; i < 8; i++)
      run3(tv[i].a, tv[i].f, tv[i].z, tv[i].o);

    // backpressure
    or3 = 1'b0;
    iv3 = 1'b1;
    id3 = 3'b110;
    tick;
    iv3 = 1'b0;
    k = 0;
    while (!ov3 && k < 20) begin
      tick;
      k++;
    end
    chk("bp_latency", 32'(k), 32'd3);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!ov3 || od3 !== 3'b010 || ir3) bad = 1'b1;
      tick;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    chk("bp_data", 32'(od3), 32'b010);
    or3 = 1'b1;
    tick;
    chk("bp_release_valid", 32'(ov3), 32'd0);
    chk("bp_release_ready", 32'(ir3), 32'd1);

    // reset mid-operation
    iv3 = 1'b1;
    id3 = 3'b001;
    tick;
    iv3 = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_ready", 32'(ir3), 32'd1);
    chk("mid_rst_valid", 32'(ov3), 32'd0);
    chk("mid_rst_data", 32'(od3), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ov3) bad = 1'b1;
      tick;
    end
    chk("mid_rst_no_result", 32'(bad), 32'd0);
    run3(3'b010, 3'b110, 1'b0, 1'b0);

    // WIDTH=8 word
    exp8 = 8'hD8;
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
    chk("ser_vld_idle", 32'(sv8), 32'd0);
`endif
    iv8 = 1'b1;
    id8 = 8'h28;
    tick;
    iv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
      chk("ser_vld_win", 32'(sv8), 32'd1);
      chk("ser_bit", 32'(sb8), 32'(exp8[i]));
`endif
      chk("w8_not_done", 32'(ov8), 32'd0);
      tick;
    end
    chk("w8_valid", 32'(ov8), 32'd1);
    chk("w8_data", 32'(od8), 32'hD8);
    chk("w8_zero", 32'(oz8), 32'd0);
    chk("w8_ovf", 32'(oo8), 32'd0);
`ifdef SERIAL_TWOS_COMP_BITSTREAM_EN
    chk("ser_vld_done", 32'(sv8), 32'd0);
`endif
    tick;

    // WIDTH=8 most negative
    iv8 = 1'b1;
    id8 = 8'h80;
    tick;
    iv8 = 1'b0;
    k = 0;
    while (!ov8 && k < 40) begin
      tick;
      k++;
    end
    chk("w8_latency", 32'(k), 32'd8);
    chk("w8_min_data", 32'(od8), 32'h80);
    chk("w8_min_ovf", 32'(oo8), 32'd1);
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
